// File: rtl/acc_lane_array.sv
// acc_lane_array: NUM_LANE lock-step accumulators, each run sums num_cnt_i valid beats.
// Build macro ACC_SAT_EN selects per-lane saturating add with sticky sat_o; default wraps.
module acc_lane_array #(
   parameter int NUM_LANE      = 4,
   parameter int IN_DATA_WIDTH = 8,
   parameter int DWIDTH        = 16,
   parameter int CNT_WIDTH     = 8
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              run_i,
   input  logic [CNT_WIDTH-1:0]              num_cnt_i,
   input  logic                              valid_i,
   input  logic [NUM_LANE*IN_DATA_WIDTH-1:0] number_i,
   output logic                              ready_o,
   output logic                              busy_o,
   output logic                              valid_o,
   output logic [NUM_LANE*DWIDTH-1:0]        result_o,
   output logic [NUM_LANE-1:0]               sat_o
);

   // Handshake: valid_i only qualifies number_i (no backpressure); a beat counts when
   // valid_i=1 in RUN without run_i. valid_o is a single-cycle strobe with no ready.
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t               state_q, state_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic [CNT_WIDTH-1:0] target_q, target_d;
   logic [CNT_WIDTH-1:0] last_cnt;
   logic [DWIDTH-1:0]    acc_q [NUM_LANE];
   logic [DWIDTH-1:0]    acc_d [NUM_LANE];
   logic [NUM_LANE-1:0]  sat_q, sat_d;
`ifdef ACC_SAT_EN
   logic [DWIDTH:0]      sum [NUM_LANE];
`endif

   assign last_cnt = target_q - CNT_WIDTH'(1);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         target_q <= '0;
         sat_q    <= '0;
         for (int k = 0; k < NUM_LANE; k++) acc_q[k] <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         target_q <= target_d;
         sat_q    <= sat_d;
         for (int k = 0; k < NUM_LANE; k++) acc_q[k] <= acc_d[k];
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      target_d = target_q;
      sat_d    = sat_q;
      for (int k = 0; k < NUM_LANE; k++) acc_d[k] = acc_q[k];
`ifdef ACC_SAT_EN
      for (int k = 0; k < NUM_LANE; k++) sum[k] = '0;
`endif
      // run_i wins in every state; a coinciding beat is dropped
      if (run_i) begin
         state_d  = (num_cnt_i == '0) ? DONE : RUN;
         cnt_d    = '0;
         target_d = num_cnt_i;
         sat_d    = '0;
         for (int k = 0; k < NUM_LANE; k++) acc_d[k] = '0;
      end else begin
         case (state_q)
            RUN: begin
               if (valid_i) begin
                  cnt_d = cnt_q + CNT_WIDTH'(1);
                  if (cnt_q == last_cnt) state_d = DONE;
                  for (int k = 0; k < NUM_LANE; k++) begin
`ifdef ACC_SAT_EN
                     sum[k] = {1'b0, acc_q[k]}
                            + (DWIDTH+1)'(number_i[k*IN_DATA_WIDTH +: IN_DATA_WIDTH]);
                     if (sum[k][DWIDTH]) begin
                        acc_d[k] = '1;
                        sat_d[k] = 1'b1;
                     end else begin
                        acc_d[k] = sum[k][DWIDTH-1:0];
                     end
`else
                     acc_d[k] = acc_q[k]
                              + DWIDTH'(number_i[k*IN_DATA_WIDTH +: IN_DATA_WIDTH]);
`endif
                  end
               end
            end
            DONE:    state_d = IDLE;
            default: state_d = state_q;
         endcase
      end
   end

   assign ready_o = (state_q == IDLE);
   assign busy_o  = (state_q == RUN);
   assign valid_o = (state_q == DONE);
   assign sat_o   = sat_q;

   for (genvar k = 0; k < NUM_LANE; k++) begin : g_lane
      assign result_o[k*DWIDTH +: DWIDTH] = acc_q[k];
   end

endmodule

// File: tb/tb_acc_lane_array.sv
// Bench for acc_lane_array: a 16-bit instance for the main tests and a 9-bit instance
// for the overflow/saturation case; expectations come from per-lane operand totals.
module tb_acc_lane_array;
   localparam int NL  = 4;
   localparam int IW  = 8;
   localparam int DW  = 16;
   localparam int CW  = 8;
   localparam int DW9 = 9;

   // clock / reset
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic              run_i, valid_i;
   logic [CW-1:0]     num_cnt_i;
   logic [NL*IW-1:0]  number_i;
   logic              ready_o, busy_o, valid_o;
   logic [NL*DW-1:0]  result_o;
   logic [NL-1:0]     sat_o;

   logic              run9, valid9;
   logic [CW-1:0]     num9;
   logic [NL*IW-1:0]  number9;
   logic              ready9, busy9, valid9_o;
   logic [NL*DW9-1:0] result9;
   logic [NL-1:0]     sat9;

   int n_tests = 0;
   int n_fail  = 0;
   logic [NL*DW-1:0] exp_q[$];

   acc_lane_array #(.NUM_LANE(NL), .IN_DATA_WIDTH(IW), .DWIDTH(DW), .CNT_WIDTH(CW)) dut (
      .clk(clk), .reset(reset), .run_i(run_i), .num_cnt_i(num_cnt_i), .valid_i(valid_i),
      .number_i(number_i), .ready_o(ready_o), .busy_o(busy_o), .valid_o(valid_o),
      .result_o(result_o), .sat_o(sat_o));

   acc_lane_array #(.NUM_LANE(NL), .IN_DATA_WIDTH(IW), .DWIDTH(DW9), .CNT_WIDTH(CW)) dut9 (
      .clk(clk), .reset(reset), .run_i(run9), .num_cnt_i(num9), .valid_i(valid9),
      .number_i(number9), .ready_o(ready9), .busy_o(busy9), .valid_o(valid9_o),
      .result_o(result9), .sat_o(sat9));

   // reference model: lane result from the plain total of its operands
   function automatic logic [NL*DW-1:0] pack16(input int unsigned t[NL]);
      logic [NL*DW-1:0] r;
      r = '0;
      for (int k = 0; k < NL; k++) r[k*DW +: DW] = DW'(t[k] % (1 << DW));
      return r;
   endfunction

   function automatic logic [NL*DW9-1:0] pack9(input int unsigned t[NL]);
      logic [NL*DW9-1:0] r;
      r = '0;
      for (int k = 0; k < NL; k++) begin
`ifdef ACC_SAT_EN
         r[k*DW9 +: DW9] = (t[k] > (1 << DW9) - 1) ? '1 : DW9'(t[k]);
`else
         r[k*DW9 +: DW9] = DW9'(t[k] % (1 << DW9));
`endif
      end
      return r;
   endfunction

   function automatic logic [NL-1:0] sat9_model(input int unsigned t[NL]);
      logic [NL-1:0] s;
      s = '0;
`ifdef ACC_SAT_EN
      for (int k = 0; k < NL; k++) s[k] = (t[k] > (1 << DW9) - 1);
`endif
      return s;
   endfunction

   function automatic logic [NL*DW-1:0] widen(input logic [NL*IW-1:0] v);
      logic [NL*DW-1:0] r;
      r = '0;
      for (int k = 0; k < NL; k++) r[k*DW +: DW] = DW'(v[k*IW +: IW]);
      return r;
   endfunction

   // driver tasks
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      run_i = 1'b0; valid_i = 1'b0; num_cnt_i = '0; number_i = '0;
      run9 = 1'b0; valid9 = 1'b0; num9 = '0; number9 = '0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      run_i = 1'b1; num_cnt_i = 8'd5;
      step();
      run_i = 1'b0; valid_i = 1'b1;
      for (int i = 0; i < 2; i++) begin
         number_i = $urandom;
         step();
      end
      n_tests++;
      if (busy_o !== 1'b1) begin
         n_fail++; $display("FAIL reset_prerun busy=%b want 1", busy_o);
      end
      reset = 1'b1; run_i = 1'b1; num_cnt_i = 8'd4; valid_i = 1'b1;
      for (int i = 0; i < 2; i++) begin
         step();
         n_tests++;
         if ({ready_o, busy_o, valid_o, sat_o} !== 7'b100_0000 || result_o !== '0) begin
            n_fail++;
            $display("FAIL reset_state rdy/bsy/vld/sat=%b%b%b%b res=%h want 1000000 res=0",
                     ready_o, busy_o, valid_o, sat_o, result_o);
         end
      end
      reset = 1'b0;
      idle_inputs();
      step();
      n_tests++;
      if ({ready_o, busy_o, valid_o} !== 3'b100 || result_o !== '0) begin
         n_fail++; $display("FAIL reset_after rdy/bsy/vld=%b%b%b res=%h want 100 res=0",
                            ready_o, busy_o, valid_o, result_o);
      end
   endtask

   task automatic test_basic();
      logic [NL*DW-1:0] e;
      run_i = 1'b1; num_cnt_i = 8'd3;
      step();
      run_i = 1'b0;
      n_tests++;
      if ({busy_o, ready_o, valid_o} !== 3'b100 || result_o !== '0) begin
         n_fail++; $display("FAIL basic_start bsy/rdy/vld=%b%b%b res=%h want 100 res=0",
                            busy_o, ready_o, valid_o, result_o);
      end
      for (int b = 1; b <= 3; b++) begin
         valid_i = 1'b1; number_i = {8'd4, 8'd3, 8'd2, 8'd1};
         step();
         e = '0;
         for (int k = 0; k < NL; k++) e[k*DW +: DW] = DW'((k + 1) * b);
         n_tests++;
         if (result_o !== e || valid_o !== (b == 3)) begin
            n_fail++; $display("FAIL basic_beat%0d res=%h vld=%b want res=%h vld=%b",
                               b, result_o, valid_o, e, (b == 3));
         end
      end
      valid_i = 1'b0;
      step();
      n_tests++;
      if (valid_o !== 1'b0 || ready_o !== 1'b1 || result_o !== e) begin
         n_fail++; $display("FAIL basic_hold vld=%b rdy=%b res=%h want vld=0 rdy=1 res=%h",
                            valid_o, ready_o, result_o, e);
      end
   endtask

   task automatic test_gaps_priority();
      logic [NL*IW-1:0] x, y, z;
      x = $urandom; y = $urandom; z = $urandom;
      run_i = 1'b1; num_cnt_i = 8'd2;
      step();
      run_i = 1'b0; valid_i = 1'b1; number_i = x;
      step();
      valid_i = 1'b0;
      step();
      step();
      n_tests++;
      if (busy_o !== 1'b1 || valid_o !== 1'b0 || result_o !== widen(x)) begin
         n_fail++; $display("FAIL gap_hold bsy=%b vld=%b res=%h want bsy=1 vld=0 res=%h",
                            busy_o, valid_o, result_o, widen(x));
      end
      run_i = 1'b1; num_cnt_i = 8'd1; valid_i = 1'b1; number_i = y;
      step();
      n_tests++;
      if (valid_o !== 1'b0 || busy_o !== 1'b1 || result_o !== '0) begin
         n_fail++; $display("FAIL restart_drop vld=%b bsy=%b res=%h want vld=0 bsy=1 res=0",
                            valid_o, busy_o, result_o);
      end
      run_i = 1'b0; number_i = z;
      step();
      valid_i = 1'b0;
      n_tests++;
      if (valid_o !== 1'b1 || result_o !== widen(z)) begin
         n_fail++; $display("FAIL restart_done vld=%b res=%h want vld=1 res=%h",
                            valid_o, result_o, widen(z));
      end
      step();
   endtask

   task automatic test_zero_length();
      run_i = 1'b1; num_cnt_i = 8'd0; valid_i = 1'b1; number_i = $urandom;
      step();
      run_i = 1'b0; valid_i = 1'b0;
      n_tests++;
      if ({valid_o, busy_o, ready_o} !== 3'b100 || result_o !== '0) begin
         n_fail++; $display("FAIL zero_done vld/bsy/rdy=%b%b%b res=%h want 100 res=0",
                            valid_o, busy_o, ready_o, result_o);
      end
      step();
      n_tests++;
      if ({valid_o, busy_o, ready_o} !== 3'b001 || result_o !== '0) begin
         n_fail++; $display("FAIL zero_idle vld/bsy/rdy=%b%b%b res=%h want 001 res=0",
                            valid_o, busy_o, ready_o, result_o);
      end
   endtask

   task automatic test_overflow();
      int unsigned tot[NL];
      logic early;
      for (int r = 0; r < 2; r++) begin
         run_i = 1'b1; num_cnt_i = 8'd255;
         step();
         run_i = 1'b0; early = 1'b0;
         for (int k = 0; k < NL; k++) tot[k] = 0;
         for (int b = 0; b < 255; b++) begin
            if ($urandom_range(0, 7) == 0) begin
               valid_i = 1'b0; step();
               if (valid_o) early = 1'b1;
            end
            valid_i = 1'b1;
            number_i = {8'($urandom), 8'($urandom), 8'($urandom), 8'hFF};
            for (int k = 0; k < NL; k++) tot[k] += number_i[k*IW +: IW];
            step();
            if (b < 254 && valid_o) early = 1'b1;
         end
         valid_i = 1'b0;
         n_tests++;
         if (valid_o !== 1'b1 || early || result_o[DW-1:0] !== 16'hFE01) begin
            n_fail++; $display("FAIL overflow_run%0d vld=%b early=%b lane0=%h want vld=1 early=0 lane0=fe01",
                               r, valid_o, early, result_o[DW-1:0]);
         end
         n_tests++;
         if (result_o !== pack16(tot)) begin
            n_fail++; $display("FAIL overflow_lanes%0d res=%h want %h", r, result_o, pack16(tot));
         end
         step();
      end
   endtask

   task automatic test_back_to_back();
      int unsigned tot[NL];
      int len;
      logic early;
      logic [NL*DW-1:0] e;
      for (int r = 0; r < 8; r++) begin
         if ($urandom_range(0, 1) == 0) begin
            idle_inputs(); step();
         end
         len = $urandom_range(1, 20);
         run_i = 1'b1; num_cnt_i = CW'(len); valid_i = 1'($urandom_range(0, 1));
         number_i = $urandom;
         step();
         run_i = 1'b0; early = valid_o;
         for (int k = 0; k < NL; k++) tot[k] = 0;
         for (int b = 0; b < len; b++) begin
            while ($urandom_range(0, 3) == 0) begin
               valid_i = 1'b0; number_i = $urandom; step();
               if (valid_o) early = 1'b1;
            end
            valid_i = 1'b1; number_i = $urandom;
            for (int k = 0; k < NL; k++) tot[k] += number_i[k*IW +: IW];
            step();
            if (b < len - 1 && valid_o) early = 1'b1;
         end
         valid_i = 1'b0;
         exp_q.push_back(pack16(tot));
         n_tests++;
         if (valid_o !== 1'b1 || early) begin
            n_fail++; $display("FAIL b2b_valid%0d vld=%b early=%b want vld=1 early=0", r, valid_o, early);
         end
         e = exp_q.pop_front();
         n_tests++;
         if (result_o !== e) begin
            n_fail++; $display("FAIL b2b_result%0d res=%h want %h", r, result_o, e);
         end
      end
      idle_inputs();
      step();
   endtask

   task automatic test_saturation();
      int unsigned tot[NL];
      for (int k = 0; k < NL; k++) tot[k] = 0;
      run9 = 1'b1; num9 = 8'd3;
      step();
      run9 = 1'b0;
      for (int b = 0; b < 3; b++) begin
         valid9 = 1'b1;
         number9 = {8'($urandom_range(0, 100)), 8'($urandom_range(0, 100)),
                    8'($urandom_range(0, 100)), 8'hFF};
         for (int k = 0; k < NL; k++) tot[k] += number9[k*IW +: IW];
         step();
      end
      valid9 = 1'b0;
      n_tests++;
      if (valid9_o !== 1'b1 || result9 !== pack9(tot) || sat9 !== sat9_model(tot)) begin
         n_fail++; $display("FAIL sat_done vld=%b res=%h sat=%b want vld=1 res=%h sat=%b",
                            valid9_o, result9, sat9, pack9(tot), sat9_model(tot));
      end
      step();
      n_tests++;
      if (result9 !== pack9(tot) || sat9 !== sat9_model(tot)) begin
         n_fail++; $display("FAIL sat_sticky res=%h sat=%b want res=%h sat=%b",
                            result9, sat9, pack9(tot), sat9_model(tot));
      end
      run9 = 1'b1; num9 = 8'd2;
      step();
      run9 = 1'b0;
      n_tests++;
      if (sat9 !== '0 || result9 !== '0 || busy9 !== 1'b1) begin
         n_fail++; $display("FAIL sat_clear sat=%b res=%h bsy=%b want sat=0 res=0 bsy=1",
                            sat9, result9, busy9);
      end
   endtask

   initial begin
      reset = 1'b1;
      idle_inputs();
      step();
      step();
      test_reset();
      test_basic();
      test_gaps_priority();
      test_zero_length();
      test_overflow();
      test_back_to_back();
      test_saturation();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
